// File: rtl/layer_sequencer.sv
// Per-frame layer scanner: fetches each layer's register set, skips disabled
// or empty layers, and offers the rest downstream over a valid/ready handshake.
module layer_sequencer #(
    parameter int NUM_LAYERS = 32,
    parameter int LAYER_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [127:0]          layer_regs,
    output logic [LAYER_BITS-1:0] pipe_layer,
    output logic                  job_valid,
    input  logic                  job_ready,
    output logic [LAYER_BITS-1:0] job_layer,
    output logic [15:0]           job_x,
    output logic [15:0]           job_y,
    output logic [15:0]           job_w,
    output logic [15:0]           job_h,
    output logic [31:0]           job_addr,
    output logic [3:0]            job_format,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        OFFER,
        NEXT,
        DONE
    } state_t;

    localparam logic [LAYER_BITS-1:0] LAST = LAYER_BITS'(NUM_LAYERS - 1);

    state_t                state;
    logic [LAYER_BITS-1:0] index;
    logic                  hold_en;
    logic                  job_ok;

    // Bits of the register set the sequencer never looks at.
    logic unused_regs;
    assign unused_regs = ^{layer_regs[15:1], layer_regs[127:116]};

    // job_* outputs are the holding registers themselves, so they stay
    // frozen from the FETCH capture until the next layer is fetched.
    assign job_ok = hold_en && (job_w != 16'd0) && (job_h != 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            index         <= '0;
            pipe_layer    <= '0;
            hold_en       <= 1'b0;
            job_valid     <= 1'b0;
            job_layer     <= '0;
            job_x         <= '0;
            job_y         <= '0;
            job_w         <= '0;
            job_h         <= '0;
            job_addr      <= '0;
            job_format    <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_start && (state != IDLE);
            frame_done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        index      <= '0;
                        pipe_layer <= '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    hold_en    <= layer_regs[0];
                    job_layer  <= index;
                    job_x      <= layer_regs[31:16];
                    job_y      <= layer_regs[47:32];
                    job_w      <= layer_regs[63:48];
                    job_h      <= layer_regs[79:64];
                    job_addr   <= {layer_regs[111:96], layer_regs[95:80]};
                    job_format <= layer_regs[115:112];
                    state      <= CHECK;
                end
                CHECK: begin
                    if (job_ok) begin
                        job_valid <= 1'b1;
                        state     <= OFFER;
                    end else begin
                        state <= NEXT;
                    end
                end
                OFFER: begin
                    if (job_ready) begin
                        job_valid <= 1'b0;
                        state     <= NEXT;
                    end
                end
                NEXT: begin
                    if (index == LAST) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        index      <= index + 1'b1;
                        pipe_layer <= index + 1'b1;
                        state      <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed vector table, reset abort sequence
// and randomized frames checked against a cycle-timeline reference model.
module tb_layer_sequencer;

    localparam int NL = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic [127:0] layer_regs;
    logic [4:0]   pipe_layer;
    logic         job_valid;
    logic         job_ready;
    logic [4:0]   job_layer;
    logic [15:0]  job_x, job_y, job_w, job_h;
    logic [31:0]  job_addr;
    logic [3:0]   job_format;
    logic         busy;
    logic         frame_done;
    logic         frame_overrun;

    logic [15:0]  regs [NL][8];
    logic [127:0] scr_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_LAYERS(NL), .LAYER_BITS(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .layer_regs   (layer_regs),
        .pipe_layer   (pipe_layer),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_layer    (job_layer),
        .job_x        (job_x),
        .job_y        (job_y),
        .job_w        (job_w),
        .job_h        (job_h),
        .job_addr     (job_addr),
        .job_format   (job_format),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun)
    );

    // Layer register file read port; scr_mask disturbs it while a job waits.
    always_comb begin
        layer_regs = '0;
        for (int r = 0; r < 8; r++)
            layer_regs[16*r +: 16] = regs[pipe_layer][r];
        layer_regs = layer_regs ^ scr_mask;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit layer_on(input int l);
        return regs[l][0][0] && (regs[l][3] != 16'd0) && (regs[l][4] != 16'd0);
    endfunction

    task automatic set_layers(input logic [31:0] mask, input logic [31:0] zw);
        for (int l = 0; l < NL; l++) begin
            regs[l][0] = {15'h7FFF, mask[l]};
            regs[l][1] = {8'(l), 8'h11};
            regs[l][2] = {8'(l), 8'h22};
            regs[l][3] = zw[l] ? 16'h0000 : 16'h0100 + 16'(l);
            regs[l][4] = 16'h0080 + 16'(l);
            regs[l][5] = 16'hBE00 + 16'(l);
            regs[l][6] = 16'h1200 + 16'(l);
            regs[l][7] = 16'hA5F0 | 16'(l % 16);
        end
        regs[5][1] = 16'h0010;
        regs[5][2] = 16'h0020;
        regs[5][3] = zw[5] ? 16'h0000 : 16'h0100;
        regs[5][4] = 16'h0080;
        regs[5][5] = 16'hBEEF;
        regs[5][6] = 16'h1234;
        regs[5][7] = 16'h0003;
    endtask

    task automatic set_random();
        for (int l = 0; l < NL; l++) begin
            for (int r = 0; r < 8; r++)
                regs[l][r] = 16'($urandom);
            if ($urandom_range(4) == 0) regs[l][3] = 16'h0000;
            if ($urandom_range(4) == 0) regs[l][4] = 16'h0000;
        end
    endtask

    // Model: a timeline of the cycle in which each layer would be fetched.
    // Skipped layers take 3 cycles; an offered layer is fetched at t,
    // offered from t+2, and the next fetch is two cycles after acceptance.
    // The fetch time of the (nonexistent) layer NL is the frame_done cycle.
    task automatic run_frame(input int rdy_pct, input int ovr_cyc,
                             input int stall_n, input bit scr_en,
                             output int done_c, output int njobs,
                             output logic [31:0] last_addr);
        int  c, lidx, t_fetch, cyc_valid;
        bit  exp_v, exp_d, exp_b, exp_o;
        lidx = 0; t_fetch = 1; cyc_valid = 0;
        done_c = -1; njobs = 0; last_addr = '0; c = 0;
        @(negedge clk);
        frame_start = 1'b1;
        job_ready   = 1'b0;
        scr_mask    = '0;
        forever begin
            @(negedge clk);
            c++;
            while (lidx < NL && !layer_on(lidx)) begin
                t_fetch += 3;
                lidx++;
            end
            exp_v = (lidx < NL) && (c >= t_fetch + 2);
            exp_d = (lidx == NL) && (c == t_fetch);
            exp_b = !((lidx == NL) && (c > t_fetch));
            exp_o = (ovr_cyc > 0) && (c == ovr_cyc + 1);
            chk("job_valid", 32'(job_valid), 32'(exp_v));
            chk("frame_done", 32'(frame_done), 32'(exp_d));
            chk("busy", 32'(busy), 32'(exp_b));
            chk("frame_overrun", 32'(frame_overrun), 32'(exp_o));
            if (frame_done) done_c = c;
            if (exp_v && job_valid) begin
                chk("job_layer", 32'(job_layer), 32'(lidx));
                chk("job_x", 32'(job_x), 32'(regs[lidx][1]));
                chk("job_y", 32'(job_y), 32'(regs[lidx][2]));
                chk("job_w", 32'(job_w), 32'(regs[lidx][3]));
                chk("job_h", 32'(job_h), 32'(regs[lidx][4]));
                chk("job_addr", job_addr, {regs[lidx][6], regs[lidx][5]});
                chk("job_format", 32'(job_format), 32'(regs[lidx][7][3:0]));
            end
            if (exp_v) begin
                if (stall_n > 0) job_ready = (cyc_valid >= stall_n);
                else job_ready = ($urandom_range(99) < rdy_pct);
                cyc_valid++;
                if (job_ready) begin
                    last_addr = {regs[lidx][6], regs[lidx][5]};
                    t_fetch = c + 2;
                    lidx++;
                    njobs++;
                    cyc_valid = 0;
                end
            end else begin
                job_ready = 1'($urandom_range(1));
            end
            scr_mask = (scr_en && exp_v && !job_ready) ?
                       {$urandom(), $urandom(), $urandom(), $urandom()} : '0;
            frame_start = (c == ovr_cyc);
            if (lidx == NL && c >= t_fetch + 3) break;
            if (c > 3000) begin
                chk("frame_timeout", 32'(c), 32'(t_fetch));
                break;
            end
        end
        frame_start = 1'b0;
        job_ready   = 1'b0;
        scr_mask    = '0;
    endtask

    typedef struct {
        logic [31:0] mask;
        logic [31:0] zw;
        int          stall;
        int          ovr;
        bit          scr;
        int          exp_done;
        int          exp_jobs;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        vecs [8];
    int          done_c, njobs;
    logic [31:0] last_addr;

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0, 0,  0,  1'b0, 97,  0,  32'h0};
        vecs[1] = '{32'h0000_0020, 32'h0, 0,  0,  1'b0, 98,  1,  32'h1234BEEF};
        vecs[2] = '{32'h0000_000C, 32'h4, 0,  0,  1'b0, 98,  1,  32'h1203BE03};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0, 0,  0,  1'b0, 129, 32, 32'h121FBE1F};
        vecs[4] = '{32'h0000_0000, 32'h0, 0,  40, 1'b0, 97,  0,  32'h0};
        vecs[5] = '{32'h0000_0008, 32'h0, 10, 0,  1'b1, 108, 1,  32'h1203BE03};
        vecs[6] = '{32'h8000_0001, 32'h0, 0,  0,  1'b0, 99,  2,  32'h121FBE1F};
        vecs[7] = '{32'h0000_0000, 32'h0, 0,  97, 1'b0, 97,  0,  32'h0};

        rst = 1'b1;
        frame_start = 1'b0;
        job_ready = 1'b0;
        scr_mask = '0;
        set_layers(32'h0, 32'h0);
        #2;
        chk("rst_job_valid", 32'(job_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pipe_layer", 32'(pipe_layer), 32'h0);
        chk("rst_job_addr", job_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            set_layers(vecs[v].mask, vecs[v].zw);
            run_frame(100, vecs[v].ovr, vecs[v].stall, vecs[v].scr,
                      done_c, njobs, last_addr);
            chk($sformatf("vec%0d_done_cycle", v), 32'(done_c), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_jobs", v), 32'(njobs), 32'(vecs[v].exp_jobs));
            chk($sformatf("vec%0d_last_addr", v), last_addr, vecs[v].exp_addr);
        end

        // Reset while a job is on offer aborts the frame silently.
        set_layers(32'h0000_0001, 32'h0);
        @(negedge clk);
        frame_start = 1'b1;
        job_ready = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 10 && !job_valid; i++) @(negedge clk);
        chk("abort_pre_valid", 32'(job_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("abort_job_valid", 32'(job_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_job_x", 32'(job_x), 32'h0);
        chk("abort_job_addr", job_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(frame_done), 32'h0);
            chk("abort_idle", 32'(busy), 32'h0);
        end
        run_frame(100, 0, 0, 1'b0, done_c, njobs, last_addr);
        chk("restart_jobs", 32'(njobs), 32'h1);
        chk("restart_addr", last_addr, 32'h1200BE00);

        for (int f = 0; f < 6; f++) begin
            set_random();
            run_frame(int'($urandom_range(100, 30)),
                      ($urandom_range(1) != 0) ? int'($urandom_range(90, 1)) : 0,
                      0, 1'b1, done_c, njobs, last_addr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter: NUM_LAYERS, default 32, number of layers scanned per frame (2..32).
REQ-002 Parameter: LAYER_BITS, default 5, width of layer index.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 frame_start  input  1  single-cycle pulse requesting one full layer scan.
REQ-006 layer_regs  input  128  register set of the layer selected by pipe_layer, combinational from the layer register file; register n at bits [16n+15:16n].
REQ-007 pipe_layer  output  LAYER_BITS  layer index driven to the register file read port.
REQ-008 job_valid  output  1  layer job offered downstream.
REQ-009 job_ready  input  1  downstream accepts job when high with job_valid.
REQ-010 job_layer  output  LAYER_BITS  index of offered layer.
REQ-011 job_x, job_y  output  16 each  layer origin (reg1, reg2).
REQ-012 job_w, job_h  output  16 each  layer size (reg3, reg4).
REQ-013 job_addr  output  32  base address, {reg6, reg5}.
REQ-014 job_format  output  4  reg7[3:0].
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  single-cycle pulse at end of scan.
REQ-017 frame_overrun  output  1  single-cycle pulse when frame_start arrives while busy.

Function
REQ-018 States SHALL be IDLE, FETCH, CHECK, OFFER, NEXT, DONE.
REQ-019 IDLE: frame_start=1 -> index:=0, go FETCH; else stay.
REQ-020 FETCH (1 cycle): pipe_layer=index; layer_regs captured into holding registers on the closing edge; go CHECK.
REQ-021 CHECK: reg0[0]=1 and reg3!=0 and reg4!=0 -> OFFER; otherwise -> NEXT (layer skipped, no job).
REQ-022 OFFER: job_valid=1; all job_* outputs driven from holding registers and stable until handshake; job_valid&&job_ready on an edge -> NEXT; job_valid never drops before acceptance.
REQ-023 NEXT: index==NUM_LAYERS-1 -> DONE; else index:=index+1, go FETCH.
REQ-024 DONE: frame_done=1 for exactly this cycle; go IDLE.
REQ-025 job_valid SHALL be high only in OFFER; frame_done only in DONE.
REQ-026 Latency: frame_start sampled at edge 0 -> FETCH layer 0 in cycle 1, CHECK cycle 2, earliest job_valid cycle 3.
REQ-027 Skipped layer costs 3 cycles (FETCH, CHECK, NEXT); accepted layer costs 4 + stall cycles.
REQ-028 Layers SHALL be scanned in ascending index order, each exactly once per frame.
REQ-029 frame_start while busy (any state but IDLE, including DONE) SHALL be ignored and pulse frame_overrun the following cycle; scan continues unaffected.
REQ-030 Changes to layer_regs after the FETCH capture SHALL NOT affect the current job.
REQ-031 pipe_layer SHALL hold its value outside FETCH (no glitch to 0).
REQ-032 Index arithmetic SHALL not wrap: NUM_LAYERS-1 is terminal via NEXT->DONE.

Reset
REQ-033 rst=1 SHALL asynchronously force state IDLE, index 0, pipe_layer 0, holding registers 0, all outputs 0.
REQ-034 rst mid-scan SHALL abort immediately with no frame_done; the pending job is dropped; after release a new frame_start is required.

Verification
REQ-035 All 32 layers disabled (reg0=0), frame_start at cycle 0 -> no job_valid; frame_done high exactly in cycle 97; busy high cycles 1..97.
REQ-036 Only layer 5 enabled, reg1=0x0010, reg2=0x0020, reg3=0x0100, reg4=0x0080, reg5=0xBEEF, reg6=0x1234, reg7=0x0003, job_ready=1 -> one job: layer 5, x=0x10, y=0x20, w=0x100, h=0x80, addr=0x1234BEEF, format=3.
REQ-037 Layer 2 enabled with reg3=0 -> skipped, no job; layer 3 enabled with w=h=1 -> job issued.
REQ-038 job_ready held 0 for 10 cycles in OFFER while layer_regs changes -> job_valid and job_* stable 10 cycles; accepted on 11th edge; next FETCH follows via NEXT.
REQ-039 frame_start pulsed in cycle 40 of a scan -> frame_overrun high in cycle 41, scan result and frame_done timing unchanged.
REQ-040 rst asserted while in OFFER -> all outputs 0 immediately, no frame_done; post-release frame_start restarts at layer 0.
